ysyx_22040088_mc_ctrl: RTL and testbench

Multi-cycle execution sequencer, the next generation of the single-cycle core top. It owns `pc`, the instruction register and the load-data register. It runs each instruction through fetch, execute, memory and write-back states, using valid/ready handshakes toward variable-latency instruction and data memories. Decode and ALU stay external: the IDU and EXU read `inst`/`pc` from this block and return decode flags and `nextpc`. The block is parametrised in data width and reset vector, and adds trap/halt reporting.

---
 rtl/ysyx_22040088_mc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ysyx_22040088_mc_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040088_mc_ctrl.sv
// Multi-cycle fetch/execute/memory/write-back sequencer with valid/ready memory ports.
// Optional performance counters are enabled by defining YSYX_22040088_MC_PERF_EN.
module ysyx_22040088_mc_ctrl #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            if_req_valid,
    input  logic            if_req_ready,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_rsp_valid,
    input  logic            if_rsp_err,
    input  logic [31:0]     if_rsp_data,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] nextpc,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_ebreak,
    input  logic            dec_rf_wen,
    output logic            mem_req_valid,
    output logic            mem_req_wr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic            mem_rsp_err,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] load_data,
    output logic            rf_wen,
    output logic            halt,
    output logic            trap,
    output logic [63:0]     instret,
    output logic [63:0]     cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_REQ,
        S_IF_WAIT,
        S_EX,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              trap_q, trap_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        load_data_d = load_data_q;
        trap_d      = trap_q;
        case (state_q)
            S_IDLE:    state_d = S_IF_REQ;
            S_IF_REQ:  if (if_req_ready) state_d = S_IF_WAIT;
            S_IF_WAIT: begin
                if (if_rsp_valid) begin
                    if (if_rsp_err) begin
                        state_d = S_HALT;
                        trap_d  = 1'b1;
                    end else begin
                        inst_d  = if_rsp_data;
                        state_d = S_EX;
                    end
                end
            end
            S_EX: begin
                // ebreak wins over a misaligned target; both win over memory access
                if (dec_ebreak) begin
                    state_d = S_HALT;
                    trap_d  = 1'b0;
                end else if (nextpc[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    trap_d  = 1'b1;
                end else if (dec_load | dec_store) begin
                    state_d = S_MEM_REQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM_REQ: if (mem_req_ready) state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        state_d = S_HALT;
                        trap_d  = 1'b1;
                    end else begin
                        if (dec_load) load_data_d = mem_rsp_data;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d    = nextpc;
                state_d = S_IF_REQ;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            load_data_q <= '0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            load_data_q <= load_data_d;
            trap_q      <= trap_d;
        end
    end

    assign if_req_valid  = (state_q == S_IF_REQ);
    assign if_req_addr   = pc_q;
    assign mem_req_valid = (state_q == S_MEM_REQ);
    assign mem_req_wr    = (state_q == S_MEM_REQ) & dec_store;
    assign rf_wen        = (state_q == S_WB) & dec_rf_wen & ~dec_store;
    assign halt          = (state_q == S_HALT);
    assign trap          = trap_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign load_data     = load_data_q;

`ifdef YSYX_22040088_MC_PERF_EN
    logic [63:0] instret_q, instret_d;
    logic [63:0] cycles_q, cycles_d;

    always_comb begin
        instret_d = instret_q;
        cycles_d  = cycles_q;
        if (state_q == S_WB) instret_d = instret_q + 64'd1;
        if ((state_q != S_IDLE) && (state_q != S_HALT)) cycles_d = cycles_q + 64'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            instret_q <= instret_d;
            cycles_q  <= cycles_d;
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`else
    assign instret = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040088_mc_ctrl.sv
// Bench for ysyx_22040088_mc_ctrl: a per-instruction timeline model predicts every output each cycle.
// Directed scenarios pin the model with literal values, then randomized instructions/delays follow.
module tb_ysyx_22040088_mc_ctrl;

    localparam logic [63:0] RPC = 64'h8000_0000;
`ifdef YSYX_22040088_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk, rst;
    logic        if_req_valid, if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_rsp_valid, if_rsp_err;
    logic [31:0] if_rsp_data, inst;
    logic [63:0] pc, nextpc;
    logic        dec_load, dec_store, dec_ebreak, dec_rf_wen;
    logic        mem_req_valid, mem_req_wr, mem_req_ready;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [63:0] mem_rsp_data, load_data;
    logic        rf_wen, halt, trap;
    logic [63:0] instret, cycles;

    ysyx_22040088_mc_ctrl #(.XLEN(64), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err), .if_rsp_data(if_rsp_data),
        .inst(inst), .pc(pc), .nextpc(nextpc),
        .dec_load(dec_load), .dec_store(dec_store), .dec_ebreak(dec_ebreak), .dec_rf_wen(dec_rf_wen),
        .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_err(mem_rsp_err), .mem_rsp_data(mem_rsp_data),
        .load_data(load_data), .rf_wen(rf_wen), .halt(halt), .trap(trap),
        .instret(instret), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk = 0, n_err = 0, cyc = 0;
    logic        chk_en = 1'b0;

    // expected outputs for the current cycle and architectural model state
    logic        e_ifv, e_mv, e_mw, e_rfw, e_halt, e_trap;
    logic [63:0] m_pc, m_load, m_busy, m_ret;
    logic [31:0] m_inst;
    logic        m_trap;

    // current instruction's decode as the IDU/EXU would present it
    logic        c_ld, c_st, c_eb, c_rf;
    logic [63:0] c_npc;

    logic        prev_ifv = 1'b0;
    int unsigned rise_q[$];
    int unsigned rfw_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("if_req_valid", {63'd0, if_req_valid}, {63'd0, e_ifv});
            chk("if_req_addr", if_req_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("mem_req_valid", {63'd0, mem_req_valid}, {63'd0, e_mv});
            if (e_mv) chk("mem_req_wr", {63'd0, mem_req_wr}, {63'd0, e_mw});
            chk("rf_wen", {63'd0, rf_wen}, {63'd0, e_rfw});
            chk("halt", {63'd0, halt}, {63'd0, e_halt});
            chk("trap", {63'd0, trap}, {63'd0, e_trap});
            chk("inst", {32'd0, inst}, {32'd0, m_inst});
            chk("load_data", load_data, m_load);
            chk("instret", instret, PERF ? m_ret : 64'd0);
            chk("cycles", cycles, PERF ? m_busy : 64'd0);
            if (if_req_valid && !prev_ifv) rise_q.push_back(cyc);
            prev_ifv = if_req_valid;
            if (rf_wen) rfw_cnt++;
        end
    end

    task automatic junk();
        if_req_ready  = 1'($urandom_range(0, 1));
        if_rsp_valid  = 1'($urandom_range(0, 1));
        if_rsp_err    = 1'($urandom_range(0, 1));
        if_rsp_data   = $urandom;
        dec_load      = 1'($urandom_range(0, 1));
        dec_store     = 1'($urandom_range(0, 1));
        dec_ebreak    = 1'($urandom_range(0, 1));
        dec_rf_wen    = 1'($urandom_range(0, 1));
        nextpc        = {$urandom, $urandom};
        mem_req_ready = 1'($urandom_range(0, 1));
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_err   = 1'($urandom_range(0, 1));
        mem_rsp_data  = {$urandom, $urandom};
    endtask

    task automatic hold_dec();
        dec_load = c_ld; dec_store = c_st; dec_ebreak = c_eb; dec_rf_wen = c_rf; nextpc = c_npc;
    endtask

    task automatic expect_out(input logic ifv, input logic mv, input logic mw, input logic rfw, input logic h);
        e_ifv = ifv; e_mv = mv; e_mw = mw; e_rfw = rfw; e_halt = h;
        e_trap = h ? m_trap : 1'b0;
    endtask

    task automatic tick(input logic busy);
        @(posedge clk);
        #1;
        if (busy) m_busy++;
    endtask

    // rd/rs/mrd/mrs: extra cycles of ready or response delay; abort_at stops inside MEM_WAIT
    task automatic run_insn(input int rd, input int rs, input logic ferr, input logic [31:0] idata,
                            input int mrd, input int mrs, input logic merr, input logic [63:0] mdata,
                            input int abort_at, output logic halted, output logic aborted);
        halted = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            junk(); if_req_ready = (i == rd); expect_out(1, 0, 0, 0, 0); tick(1);
        end
        for (int i = 0; i <= rs; i++) begin
            junk(); if_rsp_valid = (i == rs); if_rsp_err = ferr; if_rsp_data = idata;
            expect_out(0, 0, 0, 0, 0); tick(1);
        end
        if (ferr) begin m_trap = 1'b1; halted = 1'b1; return; end
        m_inst = idata;
        junk(); hold_dec(); expect_out(0, 0, 0, 0, 0); tick(1);
        if (c_eb) begin m_trap = 1'b0; halted = 1'b1; return; end
        if (c_npc[1:0] != 2'b00) begin m_trap = 1'b1; halted = 1'b1; return; end
        if (c_ld || c_st) begin
            for (int i = 0; i <= mrd; i++) begin
                junk(); hold_dec(); mem_req_ready = (i == mrd); expect_out(0, 1, c_st, 0, 0); tick(1);
            end
            for (int i = 0; i <= mrs; i++) begin
                junk(); hold_dec();
                if (i == abort_at) begin aborted = 1'b1; return; end
                mem_rsp_valid = (i == mrs); mem_rsp_err = merr; mem_rsp_data = mdata;
                expect_out(0, 0, 0, 0, 0); tick(1);
            end
            if (merr) begin m_trap = 1'b1; halted = 1'b1; return; end
            if (c_ld) m_load = mdata;
        end
        junk(); hold_dec(); expect_out(0, 0, 0, c_rf & ~c_st, 0); tick(1);
        m_pc = c_npc;
        m_ret++;
    endtask

    task automatic run_halt(input int n);
        for (int i = 0; i < n; i++) begin
            junk(); expect_out(0, 0, 0, 0, 1); tick(0);
        end
    endtask

    task automatic do_reset(input logic stale);
        rst = 1'b0;
        m_pc = RPC; m_inst = '0; m_load = '0; m_busy = '0; m_ret = '0; m_trap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            junk(); expect_out(0, 0, 0, 0, 0); tick(0);
        end
        rst = 1'b1;
        junk();
        if (stale) begin mem_rsp_valid = 1'b1; if_rsp_valid = 1'b1; end
        expect_out(0, 0, 0, 0, 0); tick(0);
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic eb, input logic rf, input logic [63:0] npc);
        c_ld = ld; c_st = st; c_eb = eb; c_rf = rf; c_npc = npc;
    endtask

    logic        h, a;
    logic [63:0] addr_tab [3];

    initial begin
        addr_tab[0] = 64'h8000_0000; addr_tab[1] = 64'h8000_0004; addr_tab[2] = 64'h8000_0008;
        rst = 1'b0;
        junk();
        set_dec(0, 0, 0, 0, RPC);
        m_pc = RPC; m_inst = '0; m_load = '0; m_busy = '0; m_ret = '0; m_trap = 1'b0;
        expect_out(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset(0);

        // three back-to-back addi with zero-wait memories
        rise_q.delete();
        rfw_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            chk("addi_fetch_addr", if_req_addr, addr_tab[k]);
            set_dec(0, 0, 0, 1, m_pc + 64'd4);
            run_insn(0, 0, 0, 32'h0010_0093, 0, 0, 0, '0, -1, h, a);
        end
        chk("addi_rf_wen_pulses", 64'(rfw_cnt), 64'd3);
        chk("addi_fetch_count", 64'(rise_q.size()), 64'd3);
        if (rise_q.size() >= 3) begin
            chk("addi_spacing_0", 64'(rise_q[1] - rise_q[0]), 64'd4);
            chk("addi_spacing_1", 64'(rise_q[2] - rise_q[1]), 64'd4);
        end
        chk("perf_instret_3", instret, PERF ? 64'd3 : 64'd0);
        chk("perf_cycles_12", cycles, PERF ? 64'd12 : 64'd0);

        // load: ready two cycles late, response three cycles after the handshake
        rise_q.delete();
        rfw_cnt = 0;
        set_dec(1, 0, 0, 1, m_pc + 64'd4);
        run_insn(0, 0, 0, 32'h0000_3083, 2, 2, 0, 64'hDEAD_BEEF_0123_4567, -1, h, a);
        chk("load_data_value", load_data, 64'hDEAD_BEEF_0123_4567);
        chk("load_rf_wen_pulses", 64'(rfw_cnt), 64'd1);
        set_dec(0, 0, 0, 1, m_pc + 64'd4);
        run_insn(0, 0, 0, 32'h0010_0093, 0, 0, 0, '0, -1, h, a);
        if (rise_q.size() >= 2) chk("load_latency", 64'(rise_q[1] - rise_q[0]), 64'd10);
        else chk("load_fetch_count", 64'(rise_q.size()), 64'd2);

        // store with dec_rf_wen set must not write the register file
        rfw_cnt = 0;
        set_dec(0, 1, 0, 1, m_pc + 64'd4);
        run_insn(0, 1, 0, 32'h0010_b023, 1, 0, 0, 64'h1111_2222_3333_4444, -1, h, a);
        chk("store_rf_wen_pulses", 64'(rfw_cnt), 64'd0);
        chk("store_keeps_load_data", load_data, 64'hDEAD_BEEF_0123_4567);

        // ebreak halts cleanly and freezes pc/inst
        set_dec(0, 0, 1, 0, m_pc + 64'd4);
        run_insn(0, 0, 0, 32'h0010_0073, 0, 0, 0, '0, -1, h, a);
        run_halt(20);
        chk("ebreak_halt", {63'd0, halt}, 64'd1);
        chk("ebreak_trap", {63'd0, trap}, 64'd0);
        chk("ebreak_pc_frozen", pc, 64'h8000_0018);
        chk("ebreak_inst_frozen", {32'd0, inst}, 64'h0010_0073);
        do_reset(0);

        // misaligned branch target traps without writing back
        rfw_cnt = 0;
        set_dec(0, 0, 0, 1, 64'h8000_0002);
        run_insn(0, 0, 0, 32'h0020_006f, 0, 0, 0, '0, -1, h, a);
        run_halt(3);
        chk("misalign_trap", {63'd0, trap}, 64'd1);
        chk("misalign_rf_wen", 64'(rfw_cnt), 64'd0);
        do_reset(0);

        // fetch error traps
        set_dec(0, 0, 0, 0, RPC);
        run_insn(1, 1, 1, 32'h0, 0, 0, 0, '0, -1, h, a);
        run_halt(3);
        chk("fetch_err_trap", {63'd0, trap}, 64'd1);
        do_reset(0);

        // reset in the middle of MEM_WAIT, stale responses right after release
        set_dec(1, 0, 0, 1, m_pc + 64'd4);
        run_insn(0, 0, 0, 32'h0000_3083, 0, 5, 0, 64'h5555_aaaa_5555_aaaa, 2, h, a);
        do_reset(1);
        chk("post_reset_fetch_addr", if_req_addr, 64'h8000_0000);
        chk("post_reset_instret", instret, 64'd0);
        chk("post_reset_cycles", cycles, 64'd0);
        set_dec(0, 0, 0, 1, m_pc + 64'd4);
        run_insn(0, 0, 0, 32'h0010_0093, 0, 0, 0, '0, -1, h, a);

        // randomized instruction mix and handshake delays
        for (int n = 0; n < 80; n++) begin
            int unsigned kind;
            logic ferr, merr;
            logic [63:0] npc;
            kind = $urandom_range(0, 31);
            npc  = {$urandom, $urandom} & ~64'd3;
            ferr = (kind == 1);
            merr = 1'b0;
            if (kind == 0)       set_dec(0, 0, 1, 1'($urandom_range(0, 1)), npc);
            else if (kind == 2)  set_dec(0, 0, 0, 1, npc | 64'($urandom_range(1, 3)));
            else if (kind <= 10) set_dec(1, 0, 0, 1'($urandom_range(0, 1)), npc);
            else if (kind <= 16) set_dec(0, 1, 0, 1'($urandom_range(0, 1)), npc);
            else                 set_dec(0, 0, 0, 1'($urandom_range(0, 1)), npc);
            if ((c_ld || c_st) && $urandom_range(0, 15) == 0) merr = 1'b1;
            run_insn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ferr, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), merr,
                     {$urandom, $urandom}, -1, h, a);
            if (h) begin
                run_halt(int'($urandom_range(2, 5)));
                do_reset(1'($urandom_range(0, 1)));
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
